// File: rtl/inst_fetch_bridge_if.sv
// Instruction-bus side of the fetch bridge: registered req/addr out, ack/rdata back.
interface inst_fetch_bridge_if;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o,
    output bus_addr_o,
    input  bus_ack_i,
    input  bus_rdata_i
  );

  modport slave (
    input  bus_req_o,
    input  bus_addr_o,
    output bus_ack_i,
    output bus_rdata_i
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// Bridges the core's single-cycle ROM port to a req/ack instruction bus through a
// one-entry fetch buffer, with stall request on miss and a watchdog that fills a NOP.
module inst_fetch_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rom_ce_i,
  input  logic [31:0]          rom_addr_i,
  output logic [31:0]          rom_data_o,
  output logic                 stallreq_o,
  input  logic                 flush_i,
  inst_fetch_bridge_if.master  bus,
  output logic                 bus_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t               state_r, state_s;
  logic                 valid_r, valid_s;
  logic [31:2]          tag_r, tag_s;
  logic [31:0]          data_r, data_s;
  logic                 bus_req_r, bus_req_s;
  logic [31:0]          bus_addr_r, bus_addr_s;
  logic [7:0]           wdog_r, wdog_s;
  logic                 bus_err_r, bus_err_s;
  logic [ERR_CNT_W-1:0] err_cnt_r, err_cnt_s;
  logic                 hit_s;
  logic                 addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^rom_addr_i[1:0];

  assign hit_s      = rom_ce_i & valid_r & (rom_addr_i[31:2] == tag_r);
  assign rom_data_o = hit_s ? data_r : 32'h0;
  // Gated by reset so the core never sees a stall while the bridge is held in reset.
  assign stallreq_o = rst & ((rom_ce_i & ~hit_s) | (state_r == REQ));

  assign bus.bus_req_o  = bus_req_r;
  assign bus.bus_addr_o = bus_addr_r;
  assign bus_err_o      = bus_err_r;
  assign err_cnt_o      = err_cnt_r;

  // Next-state and next-output logic for the miss/fill FSM.
  always_comb begin
    state_s    = state_r;
    valid_s    = valid_r;
    tag_s      = tag_r;
    data_s     = data_r;
    bus_req_s  = bus_req_r;
    bus_addr_s = bus_addr_r;
    wdog_s     = wdog_r;
    bus_err_s  = 1'b0;
    err_cnt_s  = err_cnt_r;
    case (state_r)
      IDLE: begin
        if (flush_i) begin
          valid_s = 1'b0;
        end else if (rom_ce_i && !hit_s) begin
          state_s    = REQ;
          bus_req_s  = 1'b1;
          bus_addr_s = {rom_addr_i[31:2], 2'b00};
          wdog_s     = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.bus_ack_i || (wdog_r == WDOG_LAST)) begin
          state_s   = IDLE;
          bus_req_s = 1'b0;
          // A flush on the completion edge wins over the fill.
          if (flush_i) begin
            valid_s = 1'b0;
          end else begin
            valid_s = 1'b1;
            tag_s   = bus_addr_r[31:2];
            data_s  = bus.bus_ack_i ? bus.bus_rdata_i : 32'h0;
          end
          if (bus.bus_ack_i) begin
            bus_err_s = 1'b0;
          end else begin
            bus_err_s = 1'b1;
            err_cnt_s = sat_inc(err_cnt_r);
          end
        end else begin
          wdog_s = wdog_r + 8'd1;
          if (flush_i) begin
            valid_s = 1'b0;
          end else begin
            valid_s = valid_r;
          end
        end
      end
      default: begin
        state_s   = IDLE;
        bus_req_s = 1'b0;
      end
    endcase
  end

  // State, buffer and bus output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      valid_r    <= 1'b0;
      tag_r      <= 30'h0;
      data_r     <= 32'h0;
      bus_req_r  <= 1'b0;
      bus_addr_r <= 32'h0;
      wdog_r     <= 8'd0;
      bus_err_r  <= 1'b0;
      err_cnt_r  <= {ERR_CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      valid_r    <= valid_s;
      tag_r      <= tag_s;
      data_r     <= data_s;
      bus_req_r  <= bus_req_s;
      bus_addr_r <= bus_addr_s;
      wdog_r     <= wdog_s;
      bus_err_r  <= bus_err_s;
      err_cnt_r  <= err_cnt_s;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Randomised bench for inst_fetch_bridge against a transaction-level buffer/bus model.
module tb_inst_fetch_bridge;
  localparam int T  = 4;
  localparam int EW = 2;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rom_ce;
  logic [31:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          stallreq;
  logic          flush;
  logic          bus_err;
  logic [EW-1:0] err_cnt;

  inst_fetch_bridge_if bus();

  inst_fetch_bridge #(.TIMEOUT_CYCLES(T), .ERR_CNT_W(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce),
    .rom_addr_i (rom_addr),
    .rom_data_o (rom_data),
    .stallreq_o (stallreq),
    .flush_i    (flush),
    .bus        (bus),
    .bus_err_o  (bus_err),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model: one buffered word, at most one outstanding bus transaction.
  bit          m_valid, m_busy, m_err;
  logic [31:0] m_tag, m_data, m_baddr;
  int          m_age, m_wait, m_errs;
  // Stimulus knobs: wait states for the next request (<0 = random), fixed fill data.
  int          wait_sel = -1;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = 32'h0;

  task automatic model_reset();
    m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    m_tag = 32'h0; m_data = 32'h0; m_baddr = 32'h0;
    m_age = 0; m_wait = 0; m_errs = 0;
  endtask

  // Called at a negedge; drives one cycle, checks outputs, advances the model, returns at next negedge.
  task automatic step(input bit ce, input logic [31:0] addr, input bit fl);
    bit hit, ack, done;
    logic [31:0] rd;
    hit = ce && m_valid && (addr[31:2] == m_tag[31:2]);
    ack = m_busy ? (m_age == m_wait) : ($urandom_range(0, 5) == 0);
    rd  = use_fixed ? fixed_data : $urandom();
    rom_ce = ce; rom_addr = addr; flush = fl;
    bus.bus_ack_i = ack; bus.bus_rdata_i = rd;
    #2;
    check_val("rom_data", rom_data, hit ? m_data : 32'h0);
    check_val("stallreq", {31'h0, stallreq}, {31'h0, m_busy || (ce && !hit)});
    check_val("bus_req", {31'h0, bus.bus_req_o}, {31'h0, m_busy});
    check_val("bus_addr", bus.bus_addr_o, m_baddr);
    check_val("bus_err", {31'h0, bus_err}, {31'h0, m_err});
    check_val("err_cnt", {{(32-EW){1'b0}}, err_cnt}, m_errs);
    @(posedge clk);
    m_err = 1'b0;
    if (m_busy) begin
      done = ack || (m_age + 1 == T);
      if (done) begin
        m_busy = 1'b0;
        if (fl) m_valid = 1'b0;
        else begin
          m_valid = 1'b1; m_tag = m_baddr; m_data = ack ? rd : 32'h0;
        end
        if (!ack) begin
          m_err  = 1'b1;
          m_errs = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
        end
      end else begin
        m_age++;
        if (fl) m_valid = 1'b0;
      end
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (ce && !hit) begin
      m_busy  = 1'b1;
      m_baddr = addr & 32'hFFFF_FFFC;
      m_age   = 0;
      m_wait  = (wait_sel < 0) ? $urandom_range(0, 6) : wait_sel;
    end
    @(negedge clk);
  endtask

  logic [31:0] a;

  initial begin
    model_reset();
    rom_ce = 1'b1; rom_addr = 32'h0; flush = 1'b0;
    bus.bus_ack_i = 1'b0; bus.bus_rdata_i = 32'h0;
    @(negedge clk);
    #2;
    check_val("rst_stall", {31'h0, stallreq}, 32'h0);
    check_val("rst_data", rom_data, 32'h0);
    check_val("rst_req", {31'h0, bus.bus_req_o}, 32'h0);
    check_val("rst_addr", bus.bus_addr_o, 32'h0);
    check_val("rst_err", {31'h0, bus_err}, 32'h0);
    check_val("rst_cnt", {{(32-EW){1'b0}}, err_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_sel = 1;
    repeat (5) step(1'b1, 32'h0, 1'b0);

    // Zero-wait miss then repeated hits on 0x100.
    wait_sel = 0; use_fixed = 1'b1; fixed_data = 32'h3401_1100;
    repeat (5) step(1'b1, 32'h100, 1'b0);
    // Three wait states on 0x104 (unaligned presentation of the same word too).
    wait_sel = 3; fixed_data = 32'h2402_0042;
    repeat (4) step(1'b1, 32'h104, 1'b0);
    repeat (4) step(1'b1, 32'h106, 1'b0);
    // Timeout: no ack, then keep fetching the NOP with late acks around.
    wait_sel = 50;
    repeat (9) step(1'b1, 32'h200, 1'b0);
    repeat (3) step(1'b0, 32'h200, 1'b0);
    // Flush on a hit, then flush during an outstanding request.
    wait_sel = 0; fixed_data = 32'h3401_1100;
    repeat (3) step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h100, 1'b1);
    repeat (3) step(1'b1, 32'h100, 1'b0);
    wait_sel = 2;
    step(1'b1, 32'h300, 1'b0);
    step(1'b1, 32'h300, 1'b0);
    step(1'b1, 32'h300, 1'b1);
    step(1'b1, 32'h300, 1'b0);
    step(1'b1, 32'h300, 1'b1);
    repeat (6) step(1'b1, 32'h300, 1'b0);
    // Address change while a request is outstanding.
    wait_sel = 2;
    step(1'b1, 32'h400, 1'b0);
    repeat (6) step(1'b1, 32'h500, 1'b0);

    // Reset in the second REQ cycle; bus_req must drop without a clock edge.
    wait_sel = 10;
    step(1'b1, 32'h600, 1'b0);
    step(1'b1, 32'h600, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check_val("mid_rst_req", {31'h0, bus.bus_req_o}, 32'h0);
    check_val("mid_rst_stall", {31'h0, stallreq}, 32'h0);
    check_val("mid_rst_addr", bus.bus_addr_o, 32'h0);
    check_val("mid_rst_cnt", {{(32-EW){1'b0}}, err_cnt}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_sel = 0;
    repeat (4) step(1'b1, 32'h600, 1'b0);

    // Randomised traffic over a handful of words.
    wait_sel = -1; use_fixed = 1'b0;
    a = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 4)
        a = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 8, a, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
